uart_tx_fifo: RTL and testbench

- Byte buffer between the CPU's output-port write strobe and the UART transmitter.
- Accepts single-cycle byte writes from the core and stores them in a circular FIFO.
- Presents bytes to the transmitter using its valid/ready byte handshake.
- Lets the CPU emit bursts of output without stalling on each 9600-baud frame.

---
 rtl/uart_tx_fifo.sv | 117 +++++++++++
 tb/tb_uart_tx_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO from the CPU output-port strobe to the UART transmitter; `UART_TX_CRLF_EN expands LF to CR,LF.
// Latency: a written byte is offered the cycle after its write (no fall-through); tx_data is an async read of the head.
// Backpressure: valid only while tx_data_ready; writes into a full FIFO are dropped and set sticky overflow.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              ovf_clr,
  output logic [7:0]        tx_data,
  output logic              tx_data_valid,
  input  logic              tx_data_ready
);

  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic [7:0]      mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [7:0]      head;
  logic            wr_accept;
  logic            pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty         = (wr_ptr == rd_ptr);
  assign full          = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                         (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign level         = wr_ptr - rd_ptr;
  assign wr_accept     = wr_en && !full;
  assign tx_data_valid = !empty && tx_data_ready;
  assign head          = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      // A drop in the same cycle as a clear must leave the flag set.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end
    end
  end

`ifdef UART_TX_CRLF_EN
  typedef enum logic {
    NORMAL  = 1'b0,
    LF_PEND = 1'b1
  } crlf_state_t;

  crlf_state_t state;
  crlf_state_t state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  // An LF at the head is sent twice: first as CR without popping, then as itself.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_data   = 8'h00;
    if (!empty) begin
      tx_data = head;
      case (state)
        NORMAL: begin
          if (head == 8'h0A) begin
            tx_data = 8'h0D;
            if (tx_data_valid) begin
              state_nxt = LF_PEND;
            end
          end else begin
            pop = tx_data_valid;
          end
        end
        LF_PEND: begin
          pop = tx_data_valid;
          if (tx_data_valid) begin
            state_nxt = NORMAL;
          end
        end
        default: state_nxt = NORMAL;
      endcase
    end
  end
`else
  assign pop     = tx_data_valid;
  assign tx_data = empty ? 8'h00 : head;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: per-cycle vector table plus hand sequences for frames, overflow, CRLF and async reset.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wr_data = 8'h00;
  logic       wr_en = 1'b0;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       ovf_clr = 1'b0;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready = 1'b0;

  int n_vec = 0;
  int n_bad = 0;
  int busy  = 0;
  int ncyc  = 0;
  logic [7:0] got_b [$];
  logic [4:0] got_l [$];
  int         got_c [$];
  logic [7:0] exp_q [$];

  uart_tx_fifo #(.DEPTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .wr_data       (wr_data),
    .wr_en         (wr_en),
    .full          (full),
    .empty         (empty),
    .level         (level),
    .overflow      (overflow),
    .ovf_clr       (ovf_clr),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       we;
    logic [7:0] d;
    logic       clr;
    logic       rdy;
    logic       v;
    logic [7:0] dat;
    logic       f;
    logic       e;
    logic [4:0] lvl;
    logic       ovf;
  } vec_t;

  vec_t tbl [13];

  // Inputs change on the falling edge; outputs are sampled 2 ns later, well before the rising edge.
  task automatic step(input logic r, input logic we, input logic [7:0] d, input logic clr, input logic rd);
    @(negedge clk);
    rst = r; wr_en = we; wr_data = d; ovf_clr = clr; tx_data_ready = rd;
    #2;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Transmitter model: takes a byte when idle and valid, then stays busy for 100 cycles.
  task automatic cyc(input logic we, input logic [7:0] d);
    step(1'b0, we, d, 1'b0, busy == 0);
    ncyc++;
    if (tx_data_valid) begin
      got_b.push_back(tx_data);
      got_l.push_back(level);
      got_c.push_back(ncyc);
      busy = 100;
    end else if (busy > 0) begin
      busy--;
    end
  endtask

  initial begin
    //                 rst   we    d      clr   rdy   v     dat    f     e     lvl   ovf
    tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 5'd1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b0, 1'b0, 8'hA1, 1'b0, 1'b0, 5'd1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'hA3, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 5'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hA2, 1'b0, 1'b0, 5'd2, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b0, 5'd2, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA3, 1'b0, 1'b0, 5'd1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0};

    for (int i = 0; i < 13; i++) begin
      step(tbl[i].rst, tbl[i].we, tbl[i].d, tbl[i].clr, tbl[i].rdy);
      n_vec++;
      if ({tx_data_valid, tx_data, full, empty, level, overflow} !==
          {tbl[i].v, tbl[i].dat, tbl[i].f, tbl[i].e, tbl[i].lvl, tbl[i].ovf}) begin
        n_bad++;
        $display("FAIL vec%0d: got v=%b d=%h f=%b e=%b l=%0d o=%b, expected v=%b d=%h f=%b e=%b l=%0d o=%b",
                 i, tx_data_valid, tx_data, full, empty, level, overflow,
                 tbl[i].v, tbl[i].dat, tbl[i].f, tbl[i].e, tbl[i].lvl, tbl[i].ovf);
      end
    end

    // Three bytes against a transmitter that is busy for 100 cycles after each accept.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    busy = 0;
    ncyc = 0;
    cyc(1'b1, 8'h41);
    cyc(1'b1, 8'h42);
    cyc(1'b1, 8'h43);
    for (int i = 0; i < 400 && got_b.size() < 3; i++) cyc(1'b0, 8'h00);
    chk("frame_count", 32'(got_b.size()), 3);
    if (got_b.size() == 3) begin
      chk("frame_b0", 32'(got_b[0]), 32'h41);
      chk("frame_b1", 32'(got_b[1]), 32'h42);
      chk("frame_b2", 32'(got_b[2]), 32'h43);
      chk("frame_l0", 32'(got_l[0]), 1);
      chk("frame_l1", 32'(got_l[1]), 2);
      chk("frame_l2", 32'(got_l[2]), 1);
      chk("frame_gap1", 32'(got_c[1] - got_c[0]), 101);
      chk("frame_gap2", 32'(got_c[2] - got_c[1]), 101);
    end
    cyc(1'b0, 8'h00);
    chk("frame_pulse_width", 32'(tx_data_valid), 0);
    chk("frame_empty", 32'(empty), 1);
    chk("frame_level", 32'(level), 0);

    // Fill to full, drop a 17th byte, then write-while-pop at full.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h10, 1'b0, 1'b0);
    chk("fill_full", 32'(full), 1);
    chk("fill_level", 32'(level), 16);
    chk("fill_ovf_before", 32'(overflow), 0);
    step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
    chk("drop_ovf", 32'(overflow), 1);
    chk("drop_level", 32'(level), 16);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("set_wins_over_clr", 32'(overflow), 1);
    step(1'b0, 1'b1, 8'h99, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 0);
    chk("full_pop_valid", 32'(tx_data_valid), 1);
    chk("full_pop_data", 32'(tx_data), 32'h00);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("full_pop_ovf", 32'(overflow), 1);
    chk("full_pop_level", 32'(level), 15);
    chk("full_pop_notfull", 32'(full), 0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("full_pop_ovf_clr", 32'(overflow), 0);
    exp_q.delete();
    for (int i = 1; i < 16; i++) begin
`ifdef UART_TX_CRLF_EN
      if (i == 10) exp_q.push_back(8'h0D);
`endif
      exp_q.push_back(8'(i));
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      chk($sformatf("drain_v%0d", i), 32'(tx_data_valid), 1);
      chk($sformatf("drain_d%0d", i), 32'(tx_data), 32'(exp_q[i]));
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("drain_empty", 32'(empty), 1);

    // Line feed followed by a plain byte.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h0A, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h31, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("lf_level", 32'(level), 2);
`ifdef UART_TX_CRLF_EN
    chk("lf_head_cr", 32'(tx_data), 32'h0D);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("crlf_cr_valid", 32'(tx_data_valid), 1);
    chk("crlf_cr_data", 32'(tx_data), 32'h0D);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("crlf_lf_data", 32'(tx_data), 32'h0A);
    chk("crlf_lf_level", 32'(level), 2);
`else
    chk("lf_head", 32'(tx_data), 32'h0A);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("lf_valid", 32'(tx_data_valid), 1);
    chk("lf_data", 32'(tx_data), 32'h0A);
`endif
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("lf_next_data", 32'(tx_data), 32'h31);
    chk("lf_next_level", 32'(level), 1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("lf_done_empty", 32'(empty), 1);

    // Asynchronous reset while a byte is on offer.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'hE0 + 8'(i), 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("pre_rst_valid", 32'(tx_data_valid), 1);
    chk("pre_rst_level", 32'(level), 5);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(tx_data_valid), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_level", 32'(level), 0);
    chk("arst_data", 32'(tx_data), 32'h00);
    step(1'b0, 1'b1, 8'hC3, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("post_rst_valid", 32'(tx_data_valid), 1);
    chk("post_rst_data", 32'(tx_data), 32'hC3);
    chk("post_rst_level", 32'(level), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
